// File: rtl/cp_insertion.sv
// cp_insertion: OFDM cyclic-prefix inserter. Ping-pong symbol buffers are filled from the IFFT
// stream and each is drained as its last cp_len samples followed by the full symbol.
module cp_insertion #(
    parameter int         MAX_LEN_LOG2 = 12,
    parameter logic [7:0] SR_FRAME_LEN = 8'd16,
    parameter logic [7:0] SR_CP_LEN    = 8'd17
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        cfg_err
);
    localparam int          AW      = MAX_LEN_LOG2;
    localparam int          LW      = MAX_LEN_LOG2 + 1;
    localparam logic [31:0] MAX_LEN = 32'd1 << AW;

    typedef enum logic [1:0] {IDLE, CP, SYM} state_t;

    logic            ce_rst_d;
    logic [LW-1:0]   frame_len;
    logic [31:0]     cp_len;
    logic            err_sticky;
    logic [1:0]      full;
    logic            wr_sel, rd_sel;
    logic [AW-1:0]   wr_addr, rd_addr, rd_addr_nxt, rd_addr_issue;
    logic [LW-1:0]   lat_frame [2];
    logic [LW-1:0]   lat_cp [2];
    logic [1:0]      lat_clamp;
    logic [31:0]     mem [2**(AW+1)];
    state_t          state, state_nxt;
    logic            wr_hs, wr_last, cp_big;
    logic [LW-1:0]   wr_len, rd_frame, rd_cp, cp_start;
    logic            rd_go, rd_en, in_cp, at_end, rd_free, pop;
    logic [1:0]      set_mask, clr_mask;
    logic [31:0]     fifo_data [2];
    logic [1:0]      fifo_last, fifo_cnt;
    logic            wp, rp;
    logic            unused_ok;

    assign unused_ok = i_tlast;

    always_ff @(posedge ce_clk) ce_rst_d <= ce_rst;

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            frame_len  <= LW'(64);
            cp_len     <= 32'd16;
            err_sticky <= 1'b0;
        end else if (set_stb) begin
            if (set_addr == SR_FRAME_LEN) begin
                if (set_data != 32'd0 && set_data <= MAX_LEN) frame_len <= set_data[LW-1:0];
                else err_sticky <= 1'b1;
            end
            if (set_addr == SR_CP_LEN) cp_len <= set_data;
        end
    end

    // The first sample of a symbol uses the live frame_len, since the latch happens on that same beat.
    assign i_tready = !ce_rst && !ce_rst_d && !full[wr_sel];
    assign wr_hs    = i_tvalid && i_tready;
    assign wr_len   = (wr_addr == '0) ? frame_len : lat_frame[wr_sel];
    assign wr_last  = {1'b0, wr_addr} == wr_len - LW'(1);
    assign cp_big   = cp_len > 32'(frame_len);

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            wr_sel    <= 1'b0;
            wr_addr   <= '0;
            lat_clamp <= '0;
            for (int i = 0; i < 2; i++) begin
                lat_frame[i] <= LW'(64);
                lat_cp[i]    <= LW'(16);
            end
        end else if (wr_hs) begin
            if (wr_addr == '0) begin
                lat_frame[wr_sel] <= frame_len;
                lat_cp[wr_sel]    <= cp_big ? '0 : cp_len[LW-1:0];
                lat_clamp[wr_sel] <= cp_big;
            end
            wr_addr <= wr_last ? '0 : wr_addr + AW'(1);
            if (wr_last) wr_sel <= !wr_sel;
        end
    end

    always_ff @(posedge ce_clk) begin
        if (wr_hs) mem[{wr_sel, wr_addr}] <= i_tdata;
    end

    assign set_mask = (wr_hs && wr_last) ? (2'b01 << wr_sel) : 2'b00;
    assign clr_mask = rd_free ? (2'b01 << rd_sel) : 2'b00;

    always_ff @(posedge ce_clk) begin
        if (ce_rst) full <= '0;
        else full <= (full & ~clr_mask) | set_mask;
    end

    assign rd_frame = lat_frame[rd_sel];
    assign rd_cp    = lat_cp[rd_sel];
    assign cp_start = rd_frame - rd_cp;
    assign pop      = o_tvalid && o_tready;
    assign rd_go    = pop || fifo_cnt != 2'd2;

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_sel  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            if (rd_free) rd_sel <= !rd_sel;
        end
    end

    // Both the CP and SYM phases end on address frame_len-1, so one compare marks the phase end.
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        if (rd_en) begin
            state_nxt   = in_cp ? (at_end ? SYM : CP) : (at_end ? IDLE : SYM);
            rd_addr_nxt = at_end ? '0 : rd_addr_issue + AW'(1);
        end
    end

    // IDLE issues the first read itself so a full buffer costs no extra cycle.
    always_comb begin
        in_cp         = state == CP || (state == IDLE && rd_cp != '0);
        rd_addr_issue = (state == IDLE) ? (rd_cp != '0 ? cp_start[AW-1:0] : '0) : rd_addr;
        rd_en         = !ce_rst && rd_go && (state != IDLE || full[rd_sel]);
        at_end        = {1'b0, rd_addr_issue} == rd_frame - LW'(1);
        rd_free       = rd_en && !in_cp && at_end;
    end

    // RAM reads land directly in the 2-entry skid FIFO.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            fifo_cnt     <= '0;
            wp           <= 1'b0;
            rp           <= 1'b0;
        end else begin
            if (rd_en) begin
                fifo_data[wp] <= mem[{rd_sel, rd_addr_issue}];
                fifo_last[wp] <= rd_free;
                wp            <= !wp;
            end
            if (pop) rp <= !rp;
            fifo_cnt <= fifo_cnt + 2'(rd_en) - 2'(pop);
        end
    end

    assign o_tvalid = fifo_cnt != 2'd0;
    assign o_tdata  = fifo_data[rp];
    assign o_tlast  = fifo_last[rp] && o_tvalid;
    assign cfg_err  = err_sticky || (full[rd_sel] && lat_clamp[rd_sel]);
endmodule

// File: tb/tb_cp_insertion.sv
// tb_cp_insertion: scoreboard bench for cp_insertion; expected CP+symbol streams are queued as
// each symbol is driven and compared as the DUT emits them.
module tb_cp_insertion;
    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        cfg_err;

    cp_insertion dut (
        .ce_clk(ce_clk), .ce_rst(ce_rst), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .cfg_err(cfg_err)
    );

    always #5 ce_clk = ~ce_clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    int          bubbles = 0;
    int          hs_cyc = 0;
    int          mdl_frame = 64;
    int          mdl_cp = 16;
    bit          bp_en = 0;
    bit          tp_on = 0;
    bit          tp_started = 0;
    bit          stall_prev = 0;
    logic [32:0] held, e;
    logic [32:0] exp_q [$];

    always @(posedge ce_clk) cyc <= cyc + 1;

    always @(posedge ce_clk) if (bp_en) begin
        #1;
        o_tready = 1'($urandom_range(0, 1));
    end

    always @(negedge ce_clk) begin
        if (ce_rst) stall_prev = 0;
        else begin
            if (stall_prev) begin
                n_checks++;
                if (!o_tvalid || {o_tlast, o_tdata} !== held)
                    $display("FAIL stall_hold got v=%b %h exp v=1 %h", o_tvalid, {o_tlast, o_tdata}, held);
                else n_pass++;
            end
            if (o_tvalid && o_tready) begin
                out_cnt++;
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL unexpected_output got %h exp none", {o_tlast, o_tdata});
                else begin
                    e = exp_q.pop_front();
                    if ({o_tlast, o_tdata} !== e) $display("FAIL scoreboard got %h exp %h", {o_tlast, o_tdata}, e);
                    else n_pass++;
                end
            end
            if (tp_on && o_tvalid) tp_started = 1;
            else if (tp_on && tp_started && exp_q.size() > 0) bubbles++;
            stall_prev = o_tvalid && !o_tready;
            held = {o_tlast, o_tdata};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic push_sym(input int frame, input int cp, input int base);
        int c = (cp > frame) ? 0 : cp;
        for (int k = 0; k < c; k++) exp_q.push_back({1'b0, 32'(base + frame - c + k)});
        for (int k = 0; k < frame; k++) exp_q.push_back({k == frame - 1, 32'(base + k)});
    endtask

    task automatic drive(input logic [31:0] d);
        int t = 0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        @(negedge ce_clk);
        while (!i_tready) begin
            if (++t > 3000) begin
                n_checks++;
                $display("FAIL input_timeout got i_tready=0 exp 1");
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $fatal(1, "input stuck");
            end
            @(negedge ce_clk);
        end
        hs_cyc = cyc;
        @(posedge ce_clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic send(input int base, input int n);
        for (int i = 0; i < n; i++) drive(32'(base + i));
    endtask

    task automatic wr_set(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge ce_clk);
        #1;
        set_stb = 1'b0;
        if (a == 8'd16 && d >= 1 && d <= 4096) mdl_frame = int'(d);
        if (a == 8'd17) mdl_cp = int'(d);
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while (exp_q.size() > 0 && t < limit) begin
            @(negedge ce_clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain_timeout got %0d left exp 0", exp_q.size());
        else n_pass++;
        repeat (4) @(negedge ce_clk);
        @(posedge ce_clk);
        #1;
    endtask

    task automatic test_reset;
        ce_rst = 1'b1;
        repeat (3) @(posedge ce_clk);
        @(negedge ce_clk);
        n_checks++;
        if ({o_tvalid, o_tlast, o_tdata, cfg_err, i_tready} !== 36'd0)
            $display("FAIL reset_outputs got v=%b l=%b d=%h e=%b r=%b exp all 0", o_tvalid, o_tlast, o_tdata, cfg_err, i_tready);
        else n_pass++;
        @(posedge ce_clk);
        #1;
        ce_rst = 1'b0;
        @(posedge ce_clk);
        @(negedge ce_clk);
        n_checks++;
        if (i_tready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", i_tready);
        else n_pass++;
        @(posedge ce_clk);
        #1;
    endtask

    task automatic test_default;
        int c0 = out_cnt;
        int t = 0;
        push_sym(mdl_frame, mdl_cp, 0);
        send(0, 64);
        do begin
            @(negedge ce_clk);
            t++;
        end while (!o_tvalid && t < 20);
        n_checks++;
        if (cyc - hs_cyc != 2) $display("FAIL first_latency got %0d exp 2", cyc - hs_cyc);
        else n_pass++;
        @(posedge ce_clk);
        #1;
        drain(1000);
        n_checks++;
        if (out_cnt - c0 != 80) $display("FAIL default_count got %0d exp 80", out_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int c0 = out_cnt;
        bp_en = 1;
        for (int s = 1; s <= 8; s++) begin
            push_sym(64, 16, s << 16);
            send(s << 16, 64);
        end
        drain(5000);
        bp_en = 0;
        @(posedge ce_clk);
        #2;
        o_tready = 1'b1;
        @(posedge ce_clk);
        #1;
        n_checks++;
        if (out_cnt - c0 != 640) $display("FAIL backpressure_count got %0d exp 640", out_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_reconfig;
        int c0 = out_cnt;
        push_sym(mdl_frame, mdl_cp, 'h100);
        send('h100, 11);
        wr_set(8'd16, 32'd32);
        wr_set(8'd17, 32'd8);
        send('h10b, 53);
        push_sym(mdl_frame, mdl_cp, 'h200);
        send('h200, 32);
        drain(1000);
        n_checks++;
        if (out_cnt - c0 != 120) $display("FAIL reconfig_count got %0d exp 120", out_cnt - c0);
        else n_pass++;
        wr_set(8'd16, 32'd64);
        wr_set(8'd17, 32'd16);
    endtask

    task automatic test_edge_cp;
        int c0 = out_cnt;
        int t = 0;
        wr_set(8'd17, 32'd0);
        push_sym(mdl_frame, mdl_cp, 'h300);
        send('h300, 64);
        drain(1000);
        n_checks++;
        if (out_cnt - c0 != 64) $display("FAIL cp0_count got %0d exp 64", out_cnt - c0);
        else n_pass++;
        c0 = out_cnt;
        wr_set(8'd17, 32'd64);
        push_sym(mdl_frame, mdl_cp, 'h400);
        send('h400, 64);
        drain(1000);
        n_checks++;
        if (out_cnt - c0 != 128) $display("FAIL cp_full_count got %0d exp 128", out_cnt - c0);
        else n_pass++;
        c0 = out_cnt;
        wr_set(8'd17, 32'd70);
        push_sym(mdl_frame, mdl_cp, 'h500);
        send('h500, 64);
        do begin
            @(negedge ce_clk);
            t++;
        end while (!o_tvalid && t < 20);
        n_checks++;
        if (cfg_err !== 1'b1) $display("FAIL cp_clamp_err got %b exp 1", cfg_err);
        else n_pass++;
        @(posedge ce_clk);
        #1;
        drain(1000);
        n_checks++;
        if (out_cnt - c0 != 64 || cfg_err !== 1'b0)
            $display("FAIL cp_clamp_count got %0d err=%b exp 64 err=0", out_cnt - c0, cfg_err);
        else n_pass++;
        c0 = out_cnt;
        wr_set(8'd17, 32'd16);
        wr_set(8'd16, 32'd0);
        @(negedge ce_clk);
        n_checks++;
        if (cfg_err !== 1'b1) $display("FAIL frame0_err got %b exp 1", cfg_err);
        else n_pass++;
        @(posedge ce_clk);
        #1;
        wr_set(8'd16, 32'd4097);
        push_sym(mdl_frame, mdl_cp, 'h600);
        send('h600, 64);
        drain(1000);
        n_checks++;
        if (out_cnt - c0 != 80 || cfg_err !== 1'b1)
            $display("FAIL frame0_ignored got %0d err=%b exp 80 err=1", out_cnt - c0, cfg_err);
        else n_pass++;
    endtask

    task automatic test_throughput;
        int c0 = out_cnt;
        int c5 = 0;
        int c15 = 0;
        bubbles = 0;
        tp_started = 0;
        tp_on = 1;
        for (int s = 0; s < 20; s++) begin
            push_sym(64, 16, 'h70000 + s * 256);
            for (int i = 0; i < 64; i++) begin
                drive(32'('h70000 + s * 256 + i));
                if (i == 0 && s == 5) c5 = hs_cyc;
                if (i == 0 && s == 15) c15 = hs_cyc;
            end
        end
        drain(3000);
        tp_on = 0;
        n_checks++;
        if (bubbles != 0) $display("FAIL tp_bubbles got %0d exp 0", bubbles);
        else n_pass++;
        n_checks++;
        if (out_cnt - c0 != 1600) $display("FAIL tp_count got %0d exp 1600", out_cnt - c0);
        else n_pass++;
        n_checks++;
        if (c15 - c5 != 800) $display("FAIL tp_input_rate got %0d cycles exp 800 for 640 samples", c15 - c5);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int c0;
        wr_set(8'd16, 32'd32);
        wr_set(8'd17, 32'd4);
        push_sym(mdl_frame, mdl_cp, 'h900);
        send('h900, 32);
        send('ha00, 30);
        n_checks++;
        if (cfg_err !== 1'b1) $display("FAIL pre_reset_err got %b exp 1", cfg_err);
        else n_pass++;
        ce_rst = 1'b1;
        exp_q.delete();
        @(posedge ce_clk);
        @(negedge ce_clk);
        n_checks++;
        if (o_tvalid !== 1'b0 || cfg_err !== 1'b0 || i_tready !== 1'b0)
            $display("FAIL mid_reset got v=%b e=%b r=%b exp 0 0 0", o_tvalid, cfg_err, i_tready);
        else n_pass++;
        @(posedge ce_clk);
        #1;
        ce_rst = 1'b0;
        mdl_frame = 64;
        mdl_cp = 16;
        repeat (2) @(posedge ce_clk);
        #1;
        c0 = out_cnt;
        push_sym(mdl_frame, mdl_cp, 'hb00);
        send('hb00, 64);
        drain(1000);
        n_checks++;
        if (out_cnt - c0 != 80) $display("FAIL post_reset_count got %0d exp 80", out_cnt - c0);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_default;
        test_backpressure;
        test_reconfig;
        test_edge_cp;
        test_throughput;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
